// File: rtl/multi_mode_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : counter_pkg                                            |
// | Description : Mode encodings, seed and terminal-value helpers shared |
// |               by the multi-mode counter and its next-state logic.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package counter_pkg;

  localparam logic [2:0] MODE_UP      = 3'd0;
  localparam logic [2:0] MODE_DOWN    = 3'd1;
  localparam logic [2:0] MODE_MODN_UP = 3'd2;
  localparam logic [2:0] MODE_MODN_DN = 3'd3;
  localparam logic [2:0] MODE_RING    = 3'd4;
  localparam logic [2:0] MODE_JOHNSON = 3'd5;
  localparam logic [2:0] MODE_EVEN    = 3'd6;
  localparam logic [2:0] MODE_ODD     = 3'd7;

  // Helpers work on a 16-bit container; callers truncate to WIDTH.
  function automatic logic [15:0] width_mask(input int width);
    return 16'((32'd1 << width) - 32'd1);
  endfunction

  function automatic logic [15:0] seed(input logic [2:0] mode, input int width,
                                       input int modn_dn);
    logic [15:0] s;
    case (mode)
      MODE_RING, MODE_ODD: s = 16'd1;
      MODE_MODN_DN:        s = 16'(modn_dn - 1);
      default:             s = 16'd0;
    endcase
    return s & width_mask(width);
  endfunction

  function automatic logic is_terminal(input logic [2:0] mode, input logic [15:0] count,
                                       input int width, input int modn_up);
    logic [15:0] ones;
    logic [15:0] msb;
    logic        t;
    ones = width_mask(width);
    msb  = 16'(32'd1 << (width - 1));
    case (mode)
      MODE_UP:                 t = (count == ones);
      MODE_DOWN, MODE_MODN_DN: t = (count == 16'd0);
      MODE_MODN_UP:            t = (count == 16'(modn_up - 1));
      MODE_RING, MODE_JOHNSON: t = (count == msb);
      MODE_EVEN:               t = (count == (ones - 16'd1));
      default:                 t = (count == ones);
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_mode_counter_next_state.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mmc_next_state                                         |
// | Description : Combinational step and wrap detection for each mode,   |
// |               including recovery from illegal count values.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mmc_next_state
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODN_UP = 10,
  parameter int MODN_DN = 5
) (
  input  logic [2:0]       cur_mode,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap
);

  localparam logic [WIDTH:0]   NU_TOP = (WIDTH + 1)'(MODN_UP - 1);
  localparam logic [WIDTH:0]   ND_LIM = (WIDTH + 1)'(MODN_DN);
  localparam logic [WIDTH-1:0] ND_TOP = WIDTH'(MODN_DN - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO    = WIDTH'(2);

  logic [WIDTH:0] count_x;
  assign count_x = {1'b0, count};

  always_comb begin
    next_count = count;
    case (cur_mode)
      MODE_UP:      next_count = count + ONE;
      MODE_DOWN:    next_count = count - ONE;
      // Out-of-range values collapse onto the wrap target.
      MODE_MODN_UP: next_count = (count_x >= NU_TOP) ? '0 : count + ONE;
      MODE_MODN_DN: next_count = ((count_x >= ND_LIM) || (count == '0)) ? ND_TOP : count - ONE;
      MODE_RING:    next_count = $onehot(count) ? {count[WIDTH-2:0], count[WIDTH-1]} : ONE;
      MODE_JOHNSON: next_count = {count[WIDTH-2:0], ~count[WIDTH-1]};
      MODE_EVEN:    next_count = count[0] ? {count[WIDTH-1:1], 1'b0} : count + TWO;
      MODE_ODD:     next_count = count[0] ? count + TWO : (count | ONE);
      default:      next_count = count;
    endcase
  end

  assign wrap = is_terminal(cur_mode, 16'(count), WIDTH, MODN_UP);

endmodule
`default_nettype wire

// File: rtl/multi_mode_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : multi_mode_counter                                     |
// | Description : Eight-mode WIDTH-bit counter with enable, reseed and   |
// |               terminal count. PAR_LOAD_EN adds a parallel load path. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module multi_mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODN_UP = 10,
  parameter int MODN_DN = 5
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [2:0]       Mode,
  input  logic             Preset,
  input  logic             en,
`ifdef PAR_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`endif
  output logic [WIDTH-1:0] count,
  output logic [2:0]       cur_mode,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [2:0]       mode_q,  mode_d;
  logic [WIDTH-1:0] step_val;
  logic             wrap;

  mmc_next_state #(
    .WIDTH   (WIDTH),
    .MODN_UP (MODN_UP),
    .MODN_DN (MODN_DN)
  ) u_next (
    .cur_mode   (mode_q),
    .count      (count_q),
    .next_count (step_val),
    .wrap       (wrap)
  );

  // Priority: mode change > load > Preset > step > hold.
  always_comb begin
    mode_d  = Mode;
    count_d = count_q;
    if (Mode != mode_q) begin
      count_d = WIDTH'(seed(Mode, WIDTH, MODN_DN));
    end
`ifdef PAR_LOAD_EN
    else if (load) begin
      count_d = load_val;
    end
`endif
    else if (Preset) begin
      count_d = WIDTH'(seed(mode_q, WIDTH, MODN_DN));
    end else if (en) begin
      count_d = step_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      count_q <= '0;
      mode_q  <= MODE_UP;
    end else begin
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  assign count    = count_q;
  assign cur_mode = mode_q;
  assign tc       = en & wrap;

endmodule
`default_nettype wire

// File: doc/multi_mode_counter.md
Name: multi_mode_counter

Overview:
Parametrised successor to the eight-instance fixed 4-bit counter bank. A single WIDTH-bit count register is shared across eight run-time-selectable counting modes: up, down, mod-N up, mod-N down, ring, Johnson, even and odd. It adds count enable, a per-mode seed on mode change, Preset reseed, a terminal-count flag and illegal-state recovery. It sits in the counter subsystem and is driven directly by the mode-select and control inputs.

Parameters:
WIDTH, 4, count width in bits; legal range 2..16.
MODN_UP, 10, modulus for mode 2; legal range 2..2^WIDTH.
MODN_DN, 5, modulus for mode 3; legal range 2..2^WIDTH.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
Reset  input  1  synchronous, active-low reset.
Mode  input  3  requested mode: 0 UP, 1 DOWN, 2 MODN_UP, 3 MODN_DN, 4 RING, 5 JOHNSON, 6 EVEN, 7 ODD.
Preset  input  1  synchronous reseed to the current mode's seed value.
en  input  1  count enable.
count  output  WIDTH  current count value.
cur_mode  output  3  registered active mode (mode_q).
tc  output  1  terminal count: combinational, high when en=1 and the next step wraps.

Behaviour:
- Reset (Reset=0 at an edge): count=0, cur_mode=0. Reset has highest priority.
- Priority each edge: Reset > mode change (Mode != cur_mode) > Preset > en step > hold.
- Mode change: cur_mode<=Mode and count<=seed(Mode) in the same edge. No count step that cycle.
- Seeds: RING 0..01; ODD 0..01; MODN_DN MODN_DN-1; all other modes 0.
- Preset=1 with no mode change: count<=seed(cur_mode).
- Step rules when en=1 (W=WIDTH):
  - UP: +1; all-ones wraps to 0.
  - DOWN: -1; 0 wraps to all-ones.
  - MODN_UP: +1; MODN_UP-1 wraps to 0.
  - MODN_DN: -1; 0 wraps to MODN_DN-1.
  - RING: rotate left; MSB feeds LSB.
  - JOHNSON: shift left; ~MSB feeds LSB; period 2W.
  - EVEN: +2; all-ones-1 wraps to 0.
  - ODD: +2; all-ones wraps to 1.
- Illegal-state recovery on an en step (relevant only after load or mode aliasing):
  - MODN_UP with count>=MODN_UP: go to 0.
  - MODN_DN with count>=MODN_DN: go to MODN_DN-1.
  - RING not one-hot: go to seed.
  - EVEN with LSB=1: clear LSB.
  - ODD with LSB=0: set LSB.
  - JOHNSON: no correction; any state eventually cycles.
- tc terminal values:
  - UP all-ones; DOWN 0; MODN_UP MODN_UP-1; MODN_DN 0.
  - RING and JOHNSON: MSB-only (10..0).
  - EVEN all-ones-1; ODD all-ones.
  - tc=0 whenever en=0.
- en=0: count holds. Mode change and Preset still act.
- Arithmetic is modulo 2^WIDTH. No state besides count and cur_mode.

Optional Feature:
Macro PAR_LOAD_EN.
- Defined: adds ports load (input, 1) and load_val (input, WIDTH). When load=1, count<=load_val. Priority is below mode change and above Preset. A loaded illegal value is corrected on the next en step per the recovery rules.
- Undefined: the ports are absent and no load path exists.

Decomposition:
- Package counter_pkg holds:
  - mode localparams MODE_UP..MODE_ODD (3-bit);
  - function seed(mode, WIDTH, MODN_DN);
  - function is_terminal(mode, count).
- One combinational sub-module, mmc_next_state: inputs cur_mode and count; outputs next_count and wrap. The top keeps the register, priority mux and tc gating.

Test Plan:
- Reset=0 for 2 cycles, then Mode=0, en=1 for 17 cycles: count runs 0..15, then 0; tc=1 only at count=15.
- Mode 0→2 at count=7: next count=0. Then MODN_UP=10 sequence 0..9,0; tc at 9. Mode=3: seed 4, sequence 4,3,2,1,0,4.
- Mode=4 with W=4: 0001,0010,0100,1000,0001; tc at 1000. Preset mid-run returns count to 0001.
- Mode=5: 0000,0001,0011,0111,1111,1110,1100,1000,0000 (period 8); tc at 1000.
- Mode=6 then 7: EVEN 0,2,…,14,0; ODD 1,3,…,15,1. Reset=0 asserted mid-ODD gives count=0, cur_mode=0 next edge.
- PAR_LOAD_EN defined: load 12 in MODN_UP (mod 10), en=1 gives 0. Load 0110 in RING, en=1 gives 0001. en=0 with load=0 holds count.
